// File: rtl/controller_sequencer_if.sv
// Bus between the sequencer and its environment: IR opcode, run/step controls in,
// control word, T-state ring and halt flag out.
interface controller_sequencer_if;
  logic [3:0]  opcode;
  logic        RUN;
  logic        STEP;
  logic [11:0] CON;
  logic [5:0]  T;
  logic        HLT;

  modport master (
    output opcode,
    output RUN,
    output STEP,
    input  CON,
    input  T,
    input  HLT
  );

  modport slave (
    input  opcode,
    input  RUN,
    input  STEP,
    output CON,
    output T,
    output HLT
  );
endinterface

// File: rtl/controller_sequencer.sv
// Control unit of the 8-bit accumulator computer: six-state one-hot T ring, opcode
// decode into the 12-bit control word, halt latch and run/single-step gating.
module controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic                   CLK_bar,
  input  logic                   CLR_bar,
  controller_sequencer_if.slave  bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  // Control word bit order: {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
  localparam logic [11:0] CON_IDLE     = 12'h3E3;
  localparam logic [11:0] CON_FETCH_T1 = 12'h5E3;
  localparam logic [11:0] CON_FETCH_T2 = 12'hBE3;
  localparam logic [11:0] CON_FETCH_T3 = 12'h263;
  localparam logic [11:0] CON_MEM_T4   = 12'h1A3;
  localparam logic [11:0] CON_LDA_T5   = 12'h2C3;
  localparam logic [11:0] CON_ALU_T5   = 12'h2E1;
  localparam logic [11:0] CON_ADD_T6   = 12'h3C7;
  localparam logic [11:0] CON_SUB_T6   = 12'h3CF;
  localparam logic [11:0] CON_OUT_T4   = 12'h3F2;

  t_state_e t_q, t_d;
  logic     live_q, live_d;
  logic     halted_q, halted_d;
  logic     step_q;
  logic     step_pulse;
  t_state_e ring_next;
  logic     ring_valid;
  logic [11:0] con;

  assign step_pulse = bus.STEP & ~step_q;

  always_ff @(posedge CLK_bar or negedge CLR_bar) begin
    if (!CLR_bar) begin
      t_q      <= T1;
      live_q   <= 1'b0;
      halted_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      t_q      <= t_d;
      live_q   <= live_d;
      halted_q <= halted_d;
      step_q   <= bus.STEP;
    end
  end

  // Rotation target; an illegal (non-one-hot) ring value is flagged so it can be forced back to T1.
  always_comb begin
    ring_next  = T1;
    ring_valid = 1'b1;
    case (t_q)
      T1:      ring_next = T2;
      T2:      ring_next = T3;
      T3:      ring_next = T4;
      T4:      ring_next = T5;
      T5:      ring_next = T6;
      T6:      ring_next = T1;
      default: begin
        ring_next  = T1;
        ring_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    t_d      = t_q;
    live_d   = live_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (live_q && (t_q == T4) && (bus.opcode == OP_HLT)) begin
        halted_d = 1'b1;
        live_d   = 1'b0;
      end else begin
        if (live_q) begin
          t_d = ring_next;
        end
        live_d = bus.RUN | step_pulse;
      end
    end
    if (!ring_valid) begin
      t_d = T1;
    end
  end

  // Fetch states are opcode-independent; T4..T6 decode the IR nibble, anything unknown is a NOP.
  always_comb begin
    con = CON_IDLE;
    if (live_q && !halted_q) begin
      case (t_q)
        T1: con = CON_FETCH_T1;
        T2: con = CON_FETCH_T2;
        T3: con = CON_FETCH_T3;
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: con = CON_MEM_T4;
            OP_OUT:                 con = CON_OUT_T4;
            default:                con = CON_IDLE;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA:         con = CON_LDA_T5;
            OP_ADD, OP_SUB: con = CON_ALU_T5;
            default:        con = CON_IDLE;
          endcase
        end
        T6: begin
          case (bus.opcode)
            OP_ADD:  con = CON_ADD_T6;
            OP_SUB:  con = CON_SUB_T6;
            default: con = CON_IDLE;
          endcase
        end
        default: con = CON_IDLE;
      endcase
    end
  end

  assign bus.CON = con;
  assign bus.T   = t_q;
  assign bus.HLT = halted_q;

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Control unit for the 8-bit accumulator computer.
- Six-state one-hot ring counter (T1..T6) plus instruction decode from the instruction register's opcode nibble.
- Produces the 12-bit control word that drives program counter, MAR, RAM, IR, accumulator, adder/subtractor, B and output registers.
- Also provides halt latching and a run/single-step gate so programs can be stepped one T-state at a time.

Parameters:
- OP_LDA, 4'h0, load-accumulator opcode
- OP_ADD, 4'h1, add opcode
- OP_SUB, 4'h2, subtract opcode
- OP_OUT, 4'hE, output opcode
- OP_HLT, 4'hF, halt opcode

Ports:
- CLK_bar  input  1  system clock; all state updates on its rising edge (falling edge of CLK), mid-cycle for the datapath
- CLR_bar  input  1  asynchronous active-low reset
- opcode  input  4  IR upper nibble, valid from T4
- RUN  input  1  1 = free-run, 0 = single-step
- STEP  input  1  single-step request, clean level, rising edge counted
- CON  output  12  control word {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
- T  output  6  one-hot T-state, bit0 = T1
- HLT  output  1  halted flag

Behaviour:
- Clock/reset: one clock, CLK_bar; reset CLR_bar is asynchronous, active-low.
- Reset (asynchronous, any time, including mid-instruction):
  - T=6'b000001, live=0, halted=0, step_q=0.
  - CON=12'h3E3 (all inactive), HLT=0.
- State per CLK_bar rising edge: ring T, live bit, halted bit, step_q (registered STEP).
  - step_pulse = STEP & ~step_q.
- If halted: T, live and halted all hold. Only CLR_bar exits the halt.
- Else:
  - if live=1: T rotates T1→T2→…→T6→T1.
  - live <= RUN | step_pulse.
- Halt decode: if live=1, T=T4 and opcode=OP_HLT at the edge, then halted<=1, T holds at T4, live<=0.
- CON is combinational from (live, halted, T, opcode). It equals 12'h3E3 when live=0 or halted=1; otherwise:
  - T1: 12'h5E3 (Ep, Lm_bar low)
  - T2: 12'hBE3 (Cp)
  - T3: 12'h263 (CE_bar, Li_bar low)
  - LDA: T4 12'h1A3, T5 12'h2C3, T6 12'h3E3
  - ADD: T4 12'h1A3, T5 12'h2E1, T6 12'h3C7
  - SUB: T4 12'h1A3, T5 12'h2E1, T6 12'h3CF (Su asserted in T6 only)
  - OUT: T4 12'h3F2, T5 and T6 12'h3E3
  - HLT and undefined opcodes: T4–T6 12'h3E3 (NOP)
- Latency:
  - Free-run: first live cycle is one edge after CLR_bar release with RUN=1; one T-state per clock; one instruction per 6 clocks.
  - Single-step: each STEP rising edge yields exactly one live cycle at the current T, then T advances.
  - STEP held high gives one step only.
  - A step_pulse while live=1 in step mode is absorbed (no double advance).
- Mode change: RUN 1→0 ends the live train after the current cycle and T holds. RUN 0→1 resumes from the held T with no skipped state.
- Outputs: HLT=halted; T always reflects the ring, including when halted.
- The ring must always be one-hot. Any non-one-hot value recovers to T1 on the next edge (defensive).

Test Plan:
- Reset then RUN=1, opcode=4'h0 → CON sequence 3E3, 5E3, BE3, 263, 1A3, 2C3, 3E3, 5E3…; T walks 01,02,04,08,10,20,01.
- RUN=1, opcode=4'h2 → T6 CON=12'h3CF. Opcode=4'h1 → T6 CON=12'h3C7. T5 is 12'h2E1 for both.
- RUN=1, opcode=4'hF → at T4 edge HLT=1, T=6'b001000, CON=12'h3E3 held for 20 clocks. Then pulse CLR_bar low between edges → T=01, HLT=0 asynchronously.
- RUN=0, STEP held high 5 cycles from reset → exactly one cycle of CON=12'h5E3, then T=02 and CON=12'h3E3 until the next STEP rise.
- RUN=1, opcode=4'hE, then drop RUN during T4 → T4 CON=12'h3F2 for one cycle, T holds at T5 inactive. Raising RUN resumes at T5 with 12'h3E3, then T6, then T1 with 5E3.
- Assert CLR_bar mid-T5 of an ADD → CON immediately 12'h3E3, T=01 without waiting for a clock edge.
